msf_encoder: RTL and testbench

Generates an MSF 60 kHz time-code keying signal (carrier on/off envelope) from BCD time and date fields. It is the transmit-side counterpart of the receive chain (bit sampler → decoder → time/date decoder). It drives bench loopback into the receiver and can feed an on-board test modulator. One 60-second frame is emitted per minute, with A/B bits encoded by carrier-off duration in 100 ms slots.

---
 rtl/msf_pkg.sv | 61 ++++++
 rtl/msf_slot_timer.sv | 64 ++++++
 rtl/msf_encoder.sv | 119 +++++++++++
 tb/tb_msf_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msf_pkg.sv
// msf_pkg: shared definitions for the MSF time-code encoder and the
// receive-side time/date decoder.
//   - frame geometry (slots per second, seconds per minute)
//   - A/B bit positions within the minute
//   - encoder FSM state type
//   - msf_time_t: BCD time/date fields; the packed layout lists the fields
//     in transmit order, so A bits 17..51 map onto bits 34..0.
//   - a_bit(): A-bit value for a given second of the frame
package msf_pkg;

  localparam int unsigned SLOTS_PER_SEC = 10;
  localparam int unsigned SECS_PER_MIN  = 60;

  localparam logic [5:0] YEAR_FIRST        = 6'd17;
  localparam logic [5:0] YEAR_LAST         = 6'd24;
  localparam logic [5:0] MONTH_FIRST       = 6'd25;
  localparam logic [5:0] MONTH_LAST        = 6'd29;
  localparam logic [5:0] DAY_FIRST         = 6'd30;
  localparam logic [5:0] DAY_LAST          = 6'd35;
  localparam logic [5:0] DOW_FIRST         = 6'd36;
  localparam logic [5:0] DOW_LAST          = 6'd38;
  localparam logic [5:0] HOUR_FIRST        = 6'd39;
  localparam logic [5:0] HOUR_LAST         = 6'd44;
  localparam logic [5:0] MIN_FIRST         = 6'd45;
  localparam logic [5:0] MIN_LAST          = 6'd51;
  localparam logic [5:0] MARKER_FIRST      = 6'd52;
  localparam logic [5:0] MARKER_ONES_FIRST = 6'd53;
  localparam logic [5:0] MARKER_ONES_LAST  = 6'd58;
  localparam logic [5:0] B_PAR_YEAR        = 6'd54;
  localparam logic [5:0] B_PAR_DATE        = 6'd55;
  localparam logic [5:0] B_PAR_DOW         = 6'd56;
  localparam logic [5:0] B_PAR_TIME        = 6'd57;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } enc_state_e;

  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } msf_time_t;

  function automatic logic a_bit(input msf_time_t f, input logic [5:0] s);
    logic [34:0] v;
    v = f;
    if (s >= YEAR_FIRST && s <= MIN_LAST)
      return v[MIN_LAST - s];
    return (s >= MARKER_ONES_FIRST && s <= MARKER_ONES_LAST);
  endfunction

endpackage

// File: rtl/msf_slot_timer.sv
// msf_slot_timer: prescaler plus slot (0..9) and second (0..59) counters.
//   clk_i, rst_i  clock, synchronous active-high reset
//   en_i          advance the prescaler; counters hold while low
//   slot_nxt_o    slot that is current after the next clock edge
//   second_o      registered current second
//   second_nxt_o  second that is current after the next clock edge
//   wrap_o        next edge leaves second 59 slot 9
module msf_slot_timer
  import msf_pkg::*;
#(
  parameter int unsigned CLKS_PER_SLOT = 3276
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [3:0] slot_nxt_o,
  output logic [5:0] second_o,
  output logic [5:0] second_nxt_o,
  output logic       wrap_o
);

  localparam int unsigned PW = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    slot_q, slot_d;
  logic [5:0]    second_q, second_d;
  logic          slot_end;

  always_comb begin
    presc_d  = presc_q;
    slot_d   = slot_q;
    second_d = second_q;
    slot_end = en_i && (presc_q == PW'(CLKS_PER_SLOT - 1));
    if (en_i)
      presc_d = slot_end ? '0 : presc_q + 1'b1;
    if (slot_end) begin
      if (slot_q == 4'(SLOTS_PER_SEC - 1)) begin
        slot_d   = '0;
        second_d = (second_q == 6'(SECS_PER_MIN - 1)) ? '0 : second_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
    wrap_o = slot_end && (slot_q == 4'(SLOTS_PER_SEC - 1))
                      && (second_q == 6'(SECS_PER_MIN - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      slot_q   <= '0;
      second_q <= '0;
    end else begin
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      second_q <= second_d;
    end
  end

  assign slot_nxt_o   = slot_d;
  assign second_o     = second_q;
  assign second_nxt_o = second_d;

endmodule

// File: rtl/msf_encoder.sv
// msf_encoder: MSF 60 kHz time-code keying generator.
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_i              strobe capturing the *_i BCD fields into the shadow
//   year/month/day/dow/hour/minute *_i   BCD time and date
//   data_o              1 = carrier on, 0 = carrier off
//   second_o            current second of the frame
//   minute_start_o      pulse on the first cycle of second 00
// Optional: `define MSF_ENC_PARITY_EN adds odd-parity B bits 54..57.
module msf_encoder
  import msf_pkg::*;
#(
  parameter int unsigned CLKS_PER_SLOT = 3276
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] year_h_i,
  input  logic [3:0] year_l_i,
  input  logic       month_h_i,
  input  logic [3:0] month_l_i,
  input  logic [1:0] day_h_i,
  input  logic [3:0] day_l_i,
  input  logic [2:0] dow_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] minute_h_i,
  input  logic [3:0] minute_l_i,
  output logic       data_o,
  output logic [5:0] second_o,
  output logic       minute_start_o
);

  enc_state_e state_q, state_d;
  msf_time_t  shadow_q, shadow_d, frame_q, frame_d;
  logic       data_q, data_d;
  logic       ms_q, ms_d;
  logic       start;
  logic       b_bit;
  logic [3:0] slot_nxt;
  logic [5:0] second_nxt;
  logic       wrap;

  msf_slot_timer #(
    .CLKS_PER_SLOT(CLKS_PER_SLOT)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (state_q == ST_RUN),
    .slot_nxt_o  (slot_nxt),
    .second_o    (second_o),
    .second_nxt_o(second_nxt),
    .wrap_o      (wrap)
  );

`ifdef MSF_ENC_PARITY_EN
  logic [34:0] fb;
  always_comb begin
    fb = frame_q;
    unique case (second_nxt)
      B_PAR_YEAR: b_bit = ~^fb[34:27];
      B_PAR_DATE: b_bit = ~^fb[26:16];
      B_PAR_DOW:  b_bit = ~^fb[15:13];
      B_PAR_TIME: b_bit = ~^fb[12:0];
      default:    b_bit = 1'b0;
    endcase
  end
`else
  always_comb b_bit = 1'b0;
`endif

  // Keying is computed from the timer's next slot/second so the registered
  // output changes on the very edge that enters the slot.
  always_comb begin
    start    = (state_q == ST_IDLE) && load_i;
    state_d  = start ? ST_RUN : state_q;
    shadow_d = shadow_q;
    if (load_i)
      shadow_d = '{year_h: year_h_i, year_l: year_l_i, month_h: month_h_i,
                   month_l: month_l_i, day_h: day_h_i, day_l: day_l_i,
                   dow: dow_i, hour_h: hour_h_i, hour_l: hour_l_i,
                   minute_h: minute_h_i, minute_l: minute_l_i};
    // shadow_d (not shadow_q) so a load on the wrap cycle reaches the new frame
    frame_d = (start || wrap) ? shadow_d : frame_q;
    ms_d    = start || wrap;
    data_d  = 1'b1;
    if (state_d == ST_RUN) begin
      if (second_nxt == '0) begin
        data_d = (slot_nxt >= 4'd5);
      end else begin
        case (slot_nxt)
          4'd0:    data_d = 1'b0;
          4'd1:    data_d = ~a_bit(frame_q, second_nxt);
          4'd2:    data_d = ~b_bit;
          default: data_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      frame_q  <= '0;
      data_q   <= 1'b1;
      ms_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      ms_q     <= ms_d;
    end
  end

  assign data_o         = data_q;
  assign minute_start_o = ms_q;

endmodule

// File: tb/tb_msf_encoder.sv
module tb_msf_encoder;
  import msf_pkg::*;

  localparam int CPS = 4;
  localparam int CYC_PER_SEC = CPS * 10;
  localparam int CYC_PER_MIN = CYC_PER_SEC * 60;
`ifdef MSF_ENC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      load = 1'b0;
  msf_time_t fld = '0;
  logic       data_o, minute_start_o;
  logic [5:0] second_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  msf_encoder #(.CLKS_PER_SLOT(CPS)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load),
    .year_h_i(fld.year_h), .year_l_i(fld.year_l),
    .month_h_i(fld.month_h), .month_l_i(fld.month_l),
    .day_h_i(fld.day_h), .day_l_i(fld.day_l), .dow_i(fld.dow),
    .hour_h_i(fld.hour_h), .hour_l_i(fld.hour_l),
    .minute_h_i(fld.minute_h), .minute_l_i(fld.minute_l),
    .data_o(data_o), .second_o(second_o), .minute_start_o(minute_start_o)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit field_bit(int val, int first, int w, int s);
    if (s < first || s >= first + w) return 1'b0;
    return ((val >> (first + w - 1 - s)) & 1) != 0;
  endfunction

  function automatic bit a_of(msf_time_t f, int s);
    if (s >= 53 && s <= 58) return 1'b1;
    return field_bit(f.year_h, 17, 4, s) | field_bit(f.year_l, 21, 4, s) |
           field_bit(f.month_h, 25, 1, s) | field_bit(f.month_l, 26, 4, s) |
           field_bit(f.day_h, 30, 2, s) | field_bit(f.day_l, 32, 4, s) |
           field_bit(f.dow, 36, 3, s) |
           field_bit(f.hour_h, 39, 2, s) | field_bit(f.hour_l, 41, 4, s) |
           field_bit(f.minute_h, 45, 3, s) | field_bit(f.minute_l, 48, 4, s);
  endfunction

  function automatic bit b_of(msf_time_t f, int s);
    int lo, hi, n;
    if (!PAR_EN) return 1'b0;
    case (s)
      54: begin lo = 17; hi = 24; end
      55: begin lo = 25; hi = 35; end
      56: begin lo = 36; hi = 38; end
      57: begin lo = 39; hi = 51; end
      default: return 1'b0;
    endcase
    n = 0;
    for (int i = lo; i <= hi; i++) n += int'(a_of(f, i));
    return (n % 2) == 0;
  endfunction

  function automatic bit key_of(msf_time_t f, int sec, int slot);
    if (sec == 0) return slot >= 5;
    if (slot == 0) return 1'b0;
    if (slot == 1) return !a_of(f, sec);
    if (slot == 2) return !b_of(f, sec);
    return 1'b1;
  endfunction

  bit        m_run = 1'b0;
  int        m_t = 0;
  bit        m_ms = 1'b0;
  msf_time_t m_shadow = '0, m_frame = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_ms = 1'b0; m_shadow = '0; m_frame = '0;
    end else if (!m_run) begin
      m_ms = 1'b0;
      if (load) begin
        m_run = 1'b1; m_t = 0; m_shadow = fld; m_frame = fld; m_ms = 1'b1;
      end
    end else begin
      if (load) m_shadow = fld;
      m_t++;
      m_ms = 1'b0;
      if (m_t == CYC_PER_MIN) begin
        m_t = 0; m_frame = m_shadow; m_ms = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model data_o", data_o,
          m_run ? key_of(m_frame, m_t / CYC_PER_SEC, (m_t % CYC_PER_SEC) / CPS) : 1'b1);
      chk("model second_o", second_o, m_run ? m_t / CYC_PER_SEC : 0);
      chk("model minute_start_o", minute_start_o, m_ms);
    end
  end

  // ---------------- off-duration monitor ----------------
  int off_cnt[60];
  int last_off[60];
  int exp_off[60];

  always @(negedge clk) begin
    if (minute_start_o === 1'b1) begin
      last_off = off_cnt;
      foreach (off_cnt[i]) off_cnt[i] = 0;
    end
    if (second_o < 6'd60 && data_o === 1'b0) off_cnt[second_o]++;
  end

  // abits: hand-written A17..A51; pb: hand-computed {B54,B55,B56,B57} with parity
  task automatic fill_exp(input string abits, input bit [3:0] pb);
    bit [3:0] p;
    p = PAR_EN ? pb : 4'b0000;
    for (int s = 0; s < 60; s++) begin
      if (s == 0) exp_off[s] = 20;
      else if (s >= 17 && s <= 51) exp_off[s] = (abits[s - 17] == 8'd49) ? 8 : 4;
      else if (s >= 53 && s <= 58) exp_off[s] = 8 + ((s >= 54 && s <= 57 && p[57 - s]) ? 4 : 0);
      else exp_off[s] = 4;
    end
  endtask

  task automatic cmp_frame(input string tag);
    for (int s = 0; s < 60; s++)
      chk($sformatf("%s off-cycles sec %0d", tag, s), last_off[s], exp_off[s]);
  endtask

  task automatic wait_sec(input int s);
    for (int i = 0; i < CYC_PER_MIN + 100; i++) begin
      @(negedge clk);
      if (second_o == 6'(s)) return;
    end
    chk($sformatf("timeout waiting second %0d", s), 0, 1);
  endtask

  task automatic wait_ms();
    for (int i = 0; i < CYC_PER_MIN + 100; i++) begin
      @(negedge clk);
      if (minute_start_o === 1'b1) return;
    end
    chk("timeout waiting minute_start", 0, 1);
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    foreach (off_cnt[i]) begin off_cnt[i] = 0; last_off[i] = 0; end
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    repeat (100) @(negedge clk);
    chk("idle data_o", data_o, 1);
    chk("idle second_o", second_o, 0);
    chk("idle minute_start_o", minute_start_o, 0);

    // 23:59 31-12-99 dow 6
    fld = '{year_h: 4'd9, year_l: 4'd9, month_h: 1'b1, month_l: 4'd2,
            day_h: 2'd3, day_l: 4'd1, dow: 3'd6, hour_h: 2'd2, hour_l: 4'd3,
            minute_h: 3'd5, minute_l: 4'd9};
    do_load();
    chk("start minute_start_o", minute_start_o, 1);
    chk("start data_o", data_o, 0);
    repeat (19) @(negedge clk);
    chk("marker cycle 20 data_o", data_o, 0);
    @(negedge clk);
    chk("marker cycle 21 data_o", data_o, 1);
    chk("marker second_o", second_o, 0);

    // mid-minute load of minute 05 must not touch the current frame
    wait_sec(30);
    fld.minute_h = 3'd0; fld.minute_l = 4'd5;
    do_load();
    wait_ms();
    #1;
    fill_exp({"10011001", "10010", "110001", "110", "100011", "1011001"}, 4'b1010);
    cmp_frame("frame1");

    // load on the wrap cycle (last cycle of second 59): year 01
    wait_sec(59);
    repeat (39) @(negedge clk);
    fld.year_h = 4'd0; fld.year_l = 4'd1;
    do_load();
    chk("wrap-load minute_start_o", minute_start_o, 1);
    #1;
    fill_exp({"10011001", "10010", "110001", "110", "100011", "0000101"}, 4'b1010);
    cmp_frame("frame2");

    // year 00 for the following frame
    wait_sec(10);
    fld.year_l = 4'd0;
    do_load();
    wait_ms();
    #1;
    fill_exp({"00000001", "10010", "110001", "110", "100011", "0000101"}, 4'b0010);
    cmp_frame("frame3");

    wait_ms();
    #1;
    fill_exp({"00000000", "10010", "110001", "110", "100011", "0000101"}, 4'b1010);
    cmp_frame("frame4");

    // reset mid-frame
    wait_sec(40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst data_o", data_o, 1);
    chk("rst second_o", second_o, 0);
    chk("rst minute_start_o", minute_start_o, 0);
    repeat (30) @(negedge clk);
    chk("post-rst idle data_o", data_o, 1);
    chk("post-rst idle second_o", second_o, 0);
    do_load();
    chk("restart minute_start_o", minute_start_o, 1);
    chk("restart data_o", data_o, 0);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
